// File: rtl/sequence_serializer.sv
// Parallel-to-serial pattern generator: a load handshake captures a pattern and
// its length, then the pattern is shifted out MSB-first, optionally looped.
module sequence_serializer #(
  parameter int WIDTH = 11,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic [LEN_W-1:0] load_len,
  input  logic             loop,
  input  logic             stop,
  output logic             out,
  output logic             out_valid,
  output logic             done,
  output logic             debug_state
);

  // Load handshake: a pattern transfers on a rising edge where load_valid and
  // load_ready are both high; load_ready is high exactly while the FSM is IDLE.
  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             out_d, out_valid_d, done_d;

  logic [LEN_W-1:0] eff_len;
  logic [LEN_W-1:0] shamt;
  logic [WIDTH-1:0] aligned;

  // Patterns are stored left-justified so the next bit is always the MSB.
  assign eff_len = ((load_len == '0) || (load_len > LEN_W'(WIDTH))) ? LEN_W'(WIDTH) : load_len;
  assign shamt   = LEN_W'(WIDTH) - eff_len;
  assign aligned = load_data << shamt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      pat_q     <= '0;
      sh_q      <= '0;
      cnt_q     <= '0;
      len_q     <= '0;
      out       <= 1'b0;
      out_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      pat_q     <= pat_d;
      sh_q      <= sh_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      out       <= out_d;
      out_valid <= out_valid_d;
      done      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pat_d       = pat_q;
    sh_d        = sh_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    out_d       = 1'b0;
    out_valid_d = 1'b0;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_valid) begin
          pat_d       = aligned;
          len_d       = eff_len;
          cnt_d       = eff_len;
          out_d       = aligned[WIDTH-1];
          sh_d        = aligned << 1;
          out_valid_d = 1'b1;
          state_d     = SHIFT;
        end
      end
      SHIFT: begin
        // cnt_q counts the bits of this pass still on the wire, including the current one.
        if (stop) begin
          state_d = IDLE;
        end else if (cnt_q == LEN_W'(1)) begin
          if (loop) begin
            out_d       = pat_q[WIDTH-1];
            sh_d        = pat_q << 1;
            cnt_d       = len_q;
            out_valid_d = 1'b1;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else begin
          out_d       = sh_q[WIDTH-1];
          sh_d        = sh_q << 1;
          cnt_d       = cnt_q - LEN_W'(1);
          out_valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign load_ready  = (state_q == IDLE);
  assign debug_state = state_q;

endmodule

// File: tb/tb_sequence_serializer.sv
// Directed bench for sequence_serializer: stimulus pushes expected serial
// words into a queue, a negedge monitor pops and compares every output event.
module tb_sequence_serializer;

  localparam int WIDTH = 11;
  localparam int LEN_W = 4;

  logic             clk;
  logic             reset;
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_data;
  logic [LEN_W-1:0] load_len;
  logic             loop;
  logic             stop;
  logic             out;
  logic             out_valid;
  logic             done;
  logic             debug_state;

  int n_pass  = 0;
  int n_total = 0;

  // Entries are {done, out_valid, out}: a data bit is {0,1,b}, a done pulse {1,0,0}.
  logic [2:0] exp_q[$];

  sequence_serializer #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .load_len   (load_len),
    .loop       (loop),
    .stop       (stop),
    .out        (out),
    .out_valid  (out_valid),
    .done       (done),
    .debug_state(debug_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Driver tasks
  task automatic push_bits(input logic [15:0] v, input int n, input bit with_done);
    for (int i = n - 1; i >= 0; i--) exp_q.push_back({2'b01, v[i]});
    if (with_done) exp_q.push_back(3'b100);
  endtask

  task automatic load(input logic [WIDTH-1:0] d, input logic [LEN_W-1:0] l);
    int t = 0;
    while (!load_ready && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (!load_ready) check("load_ready_timeout", 32'(load_ready), 32'd1);
    load_valid = 1'b1;
    load_data  = d;
    load_len   = l;
    @(posedge clk); #1;
    load_valid = 1'b0;
    load_data  = '0;
    load_len   = '0;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(posedge clk);
      t++;
    end
    #1;
    if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (reset && (out_valid || done)) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_output: got {done,valid,out}=%b with empty queue at %0t",
                 {done, out_valid, out}, $time);
      end else begin
        check("serial_word", 32'({done, out_valid, out}), 32'(exp_q.pop_front()));
      end
      if (out_valid) check("load_ready_busy", 32'(load_ready), 32'd0);
    end
  end

  initial begin
    reset      = 1'b0;
    load_valid = 1'b1;
    load_data  = 11'h5B7;
    load_len   = 4'd11;
    loop       = 1'b0;
    stop       = 1'b0;

    // Reset held with load_valid asserted: nothing may start.
    repeat (2) begin
      @(negedge clk);
      check("rst_out", 32'(out), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_load_ready", 32'(load_ready), 32'd1);
    end
    load_valid = 1'b0;
    #1 reset = 1'b1;
    @(posedge clk); #1;

    // Full width, short with masked upper bits, len 0 and len 15 clamp, back to back.
    push_bits(16'b101_1011_0111, 11, 1'b1);
    load(11'h5B7, 4'd11);
    push_bits(16'b110, 3, 1'b1);
    load(11'h7F6, 4'd3);
    push_bits(16'b101_1011_0111, 11, 1'b1);
    load(11'h5B7, 4'd0);
    push_bits(16'b101_1011_0111, 11, 1'b1);
    load(11'h5B7, 4'd15);
    drain();

    // Loop mode: three passes, loop dropped during pass 3.
    push_bits(16'b1011, 4, 1'b0);
    push_bits(16'b1011, 4, 1'b0);
    push_bits(16'b1011, 4, 1'b1);
    loop = 1'b1;
    load(11'h00B, 4'd4);
    repeat (10) @(posedge clk);
    #1 loop = 1'b0;
    drain();

    // Abort on the 5th bit, then an immediate new load.
    push_bits(16'b10110, 5, 1'b0);
    load(11'h5B7, 4'd11);
    repeat (4) @(posedge clk);
    #1 stop = 1'b1;
    @(posedge clk);
    #1 stop = 1'b0;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_out", 32'(out), 32'd0);
    check("abort_load_ready", 32'(load_ready), 32'd1);
    push_bits(16'b110, 3, 1'b1);
    load(11'h7F6, 4'd3);
    drain();

    // Asynchronous reset while bit 6 is on the wire.
    push_bits(16'b10110, 5, 1'b0);
    load(11'h5B7, 4'd11);
    repeat (5) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("async_out_valid", 32'(out_valid), 32'd0);
    check("async_out", 32'(out), 32'd0);
    check("async_done", 32'(done), 32'd0);
    check("async_load_ready", 32'(load_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("post_reset_idle", 32'(load_ready), 32'd1);
    check("post_reset_out_valid", 32'(out_valid), 32'd0);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
